// File: rtl/pipe_stage_buf_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_buf_if
//  Description : Valid/ready beat channel carrying LANES x DATA_W payload
//                with per-lane valid bits.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_buf_if #(
   parameter int DATA_W = 64,
   parameter int LANES  = 2
) ();
   logic                      valid;
   logic                      ready;
   logic [LANES-1:0]          lane_valid;
   logic [LANES*DATA_W-1:0]   data;

   modport master (
      output valid,
      output lane_valid,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  lane_valid,
      input  data,
      output ready
   );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_buf
//  Description : Pipeline stage register with 2-entry skid buffer, registered
//                upstream ready, synchronous flush and bubble discard.
//                Define PIPE_STAGE_PERF_EN to add stall/flush perf counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_buf #(
   parameter int DATA_W = 64,
   parameter int LANES  = 2
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             flush,
   pipe_stage_buf_if.slave       up,
   pipe_stage_buf_if.master      dn,
`ifdef PIPE_STAGE_PERF_EN
   output logic [31:0]           perf_stall_cnt,
   output logic [15:0]           perf_flush_cnt,
`endif
   output logic [1:0]            occupancy
);

   localparam int c_BEAT_W = LANES * DATA_W;

   // State encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_HALF  = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t                r_state;
   logic                  r_in_ready;
   logic [LANES-1:0]      r_main_lv;
   logic [c_BEAT_W-1:0]   r_main_data;
   logic [LANES-1:0]      r_skid_lv;
   logic [c_BEAT_W-1:0]   r_skid_data;

   logic                  w_out_valid;
   logic                  w_accept;
   logic                  w_drain;

   assign w_out_valid = (r_state != S_EMPTY);
   assign w_accept    = up.valid & r_in_ready & ~flush & (|up.lane_valid);
   assign w_drain     = w_out_valid & dn.ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_EMPTY;
         r_in_ready  <= 1'b1;
         r_main_lv   <= '0;
         r_main_data <= '0;
         r_skid_lv   <= '0;
         r_skid_data <= '0;
      end else if (flush) begin
         r_state     <= S_EMPTY;
         r_in_ready  <= 1'b1;
         r_main_lv   <= '0;
         r_main_data <= '0;
         r_skid_lv   <= '0;
         r_skid_data <= '0;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_accept) begin
                  r_main_lv   <= up.lane_valid;
                  r_main_data <= up.data;
                  r_state     <= S_HALF;
               end
            end
            S_HALF: begin
               if (w_accept && w_drain) begin
                  r_main_lv   <= up.lane_valid;
                  r_main_data <= up.data;
               end else if (w_accept) begin
                  r_skid_lv   <= up.lane_valid;
                  r_skid_data <= up.data;
                  r_state     <= S_FULL;
                  r_in_ready  <= 1'b0;
               end else if (w_drain) begin
                  // Storage is cleared so an empty stage presents a zero bubble.
                  r_main_lv   <= '0;
                  r_main_data <= '0;
                  r_state     <= S_EMPTY;
               end
            end
            S_FULL: begin
               if (w_drain) begin
                  r_main_lv   <= r_skid_lv;
                  r_main_data <= r_skid_data;
                  r_skid_lv   <= '0;
                  r_skid_data <= '0;
                  r_state     <= S_HALF;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state     <= S_EMPTY;
               r_in_ready  <= 1'b1;
               r_main_lv   <= '0;
               r_main_data <= '0;
               r_skid_lv   <= '0;
               r_skid_data <= '0;
            end
         endcase
      end
   end

   assign up.ready      = r_in_ready;
   assign dn.valid      = w_out_valid;
   assign dn.lane_valid = r_main_lv;
   assign dn.data       = r_main_data;
   assign occupancy     = r_state;

`ifdef PIPE_STAGE_PERF_EN
   logic [31:0] r_stall_cnt;
   logic [15:0] r_flush_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_out_valid && !dn.ready && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 32'd1;
         if (flush && (r_state != S_EMPTY) && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + 16'd1;
      end
   end

   assign perf_stall_cnt = r_stall_cnt;
   assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_buf
//  Description : Directed and randomized bench for pipe_stage_buf against a
//                queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_buf;

   localparam int DW = 64;
   localparam int LN = 2;
   localparam int W  = DW * LN;

   typedef struct {
      logic [LN-1:0] lv;
      logic [W-1:0]  d;
   } beat_t;

   logic        clk;
   logic        rst;
   logic        flush;
   logic [1:0]  occupancy;
`ifdef PIPE_STAGE_PERF_EN
   logic [31:0] perf_stall_cnt;
   logic [15:0] perf_flush_cnt;
   logic [31:0] exp_stall;
   logic [15:0] exp_flush;
`endif

   pipe_stage_buf_if #(.DATA_W(DW), .LANES(LN)) up_if ();
   pipe_stage_buf_if #(.DATA_W(DW), .LANES(LN)) dn_if ();

   pipe_stage_buf #(.DATA_W(DW), .LANES(LN)) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .up             (up_if),
      .dn             (dn_if),
`ifdef PIPE_STAGE_PERF_EN
      .perf_stall_cnt (perf_stall_cnt),
      .perf_flush_cnt (perf_flush_cnt),
`endif
      .occupancy      (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    n_chk;
   int    n_pass;
   beat_t q[$];

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      q.delete();
`ifdef PIPE_STAGE_PERF_EN
      exp_stall = '0;
      exp_flush = '0;
`endif
   endtask

   task automatic check_all(input string tag);
      int sz;
      sz = q.size();
      chk({tag, "_valid"}, W'(dn_if.valid), W'(sz != 0));
      chk({tag, "_occ"},   W'(occupancy),   W'(sz));
      chk({tag, "_rdy"},   W'(up_if.ready), W'(sz < 2));
      chk({tag, "_lv"},    W'(dn_if.lane_valid), (sz != 0) ? W'(q[0].lv) : '0);
      chk({tag, "_data"},  dn_if.data,           (sz != 0) ? q[0].d : '0);
`ifdef PIPE_STAGE_PERF_EN
      chk({tag, "_stall"}, W'(perf_stall_cnt), W'(exp_stall));
      chk({tag, "_flcnt"}, W'(perf_flush_cnt), W'(exp_flush));
`endif
   endtask

   // One clock: drive inputs, advance model at the edge, check at negedge.
   task automatic step(input string tag, input logic v, input logic [LN-1:0] lv,
                       input logic [W-1:0] d, input logic ordy, input logic fl,
                       output logic taken);
      int sz;
      up_if.valid      = v;
      up_if.lane_valid = lv;
      up_if.data       = d;
      dn_if.ready      = ordy;
      flush            = fl;
      @(posedge clk);
      sz    = q.size();
      taken = v && (sz < 2) && !fl;
`ifdef PIPE_STAGE_PERF_EN
      if (sz > 0 && !ordy && exp_stall != '1) exp_stall = exp_stall + 32'd1;
      if (fl && sz > 0 && exp_flush != '1)    exp_flush = exp_flush + 16'd1;
`endif
      if (fl) begin
         q.delete();
      end else begin
         if (sz > 0 && ordy) void'(q.pop_front());
         if (taken && lv != '0) q.push_back('{lv, d});
      end
      @(negedge clk);
      check_all(tag);
   endtask

   function automatic logic [W-1:0] rnd_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic t;
      n_chk  = 0;
      n_pass = 0;
      rst    = 1'b0;
      flush  = 1'b0;
      up_if.valid      = 1'b0;
      up_if.lane_valid = '0;
      up_if.data       = '0;
      dn_if.ready      = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_all("reset");
      rst = 1'b1;

      for (int k = 0; k < 8; k++)
         step("stream", 1'b1, 2'b11, W'(k), 1'b1, 1'b0, t);
      step("stream_end", 1'b0, 2'b00, '0, 1'b1, 1'b0, t);

      step("bp_a", 1'b1, 2'b11, W'(16'hA), 1'b0, 1'b0, t);
      step("bp_b", 1'b1, 2'b11, W'(16'hB), 1'b0, 1'b0, t);
      chk("bp_full_occ", W'(occupancy), W'(2));
      chk("bp_full_rdy", W'(up_if.ready), W'(0));
      step("bp_c_hold", 1'b1, 2'b11, W'(16'hC), 1'b0, 1'b0, t);
      chk("bp_c_not_taken", W'(t), W'(0));
      for (int i = 0; i < 4 && !t; i++)
         step("bp_c_retry", 1'b1, 2'b11, W'(16'hC), 1'b1, 1'b0, t);
      chk("bp_c_taken", W'(t), W'(1));
      repeat (3) step("bp_drain", 1'b0, 2'b00, '0, 1'b1, 1'b0, t);

      step("fl_a", 1'b1, 2'b11, rnd_data(), 1'b0, 1'b0, t);
      step("fl_b", 1'b1, 2'b11, rnd_data(), 1'b0, 1'b0, t);
      step("fl_d", 1'b1, 2'b11, W'(16'hD), 1'b0, 1'b1, t);
      chk("fl_occ", W'(occupancy), W'(0));
      chk("fl_valid", W'(dn_if.valid), W'(0));
      chk("fl_rdy", W'(up_if.ready), W'(1));
      step("fl_after", 1'b0, 2'b00, '0, 1'b1, 1'b0, t);

      step("bub_e", 1'b1, 2'b11, W'(16'hE), 1'b0, 1'b0, t);
      step("bub_zero", 1'b1, 2'b00, W'(16'hF), 1'b0, 1'b0, t);
      chk("bub_occ", W'(occupancy), W'(1));
      step("bub_drain", 1'b0, 2'b00, '0, 1'b1, 1'b0, t);
      step("bub_lane0", 1'b1, 2'b01, {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888},
           1'b0, 1'b0, t);
      chk("bub_lv01", W'(dn_if.lane_valid), W'(2'b01));
      chk("bub_lane1_data", W'(dn_if.data[DW +: DW]), W'(64'h1111_2222_3333_4444));
      step("bub_out", 1'b0, 2'b00, '0, 1'b1, 1'b0, t);

      step("rf_a", 1'b1, 2'b11, rnd_data(), 1'b0, 1'b0, t);
      step("rf_b", 1'b1, 2'b11, rnd_data(), 1'b0, 1'b0, t);
      up_if.valid = 1'b0;
      rst = 1'b0;
      #1;
      model_reset();
      check_all("rst_mid");
      chk("rst_mid_data", dn_if.data, '0);
      @(negedge clk);
      rst = 1'b1;
      chk("rst_rel_rdy", W'(up_if.ready), W'(1));

`ifdef PIPE_STAGE_PERF_EN
      step("pf_fill", 1'b1, 2'b11, rnd_data(), 1'b0, 1'b0, t);
      repeat (5) step("pf_stall", 1'b0, 2'b00, '0, 1'b0, 1'b0, t);
      step("pf_fl1", 1'b0, 2'b00, '0, 1'b1, 1'b1, t);
      step("pf_refill", 1'b1, 2'b11, rnd_data(), 1'b1, 1'b0, t);
      step("pf_fl2", 1'b0, 2'b00, '0, 1'b1, 1'b1, t);
      chk("pf_stall5", W'(perf_stall_cnt), W'(5));
      chk("pf_flush2", W'(perf_flush_cnt), W'(2));
`endif

      for (int i = 0; i < 400; i++)
         step("rand", 1'($urandom_range(0, 3) != 0), LN'($urandom_range(0, 3)), rnd_data(),
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0), t);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised pipeline stage register; successor to the fixed single-instruction IF/ID latch. Carries LANES lanes of DATA_W-bit payload with per-lane valid bits. Uses a valid/ready handshake backed by a 2-entry skid buffer, so upstream ready is registered and does not depend combinationally on downstream ready. Supports synchronous flush (mispredict/redirect) and bubble discard. Placed between any two core stages (IF/ID, ID/EX, ...).

Parameters:
DATA_W, 64, payload bits per lane (e.g. inst+pc+predict+predict_pc)
LANES, 2, number of parallel lanes (fetch/issue width), >=1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (rst=0 resets)
flush  in  1  synchronous kill of all held entries
in_valid  in  1  upstream beat present
in_ready  out  1  stage can accept a beat (registered)
in_lane_valid  in  LANES  per-lane valid of incoming beat
in_data  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
out_valid  out  1  output beat present
out_ready  in  1  downstream accepts output beat
out_lane_valid  out  LANES  per-lane valid of output beat
out_data  out  LANES*DATA_W  output payload
occupancy  out  2  entries held: 0, 1 or 2

Behaviour:
- Storage: main entry (drives outputs) and skid entry. States EMPTY (occ 0), HALF (main only), FULL (main+skid).
- Accept = in_valid & in_ready & ~flush & (in_lane_valid != 0). Beat with in_valid & in_ready and in_lane_valid==0 is consumed but not stored (bubble discard).
- Drain = out_valid & out_ready.
- EMPTY: accept -> HALF (beat into main). out_valid=0.
- HALF: accept & drain -> HALF (new beat replaces main); accept & ~drain -> FULL (beat into skid); ~accept & drain -> EMPTY; else hold.
- FULL: drain -> HALF (skid moves to main, skid cleared). No accept possible (in_ready=0).
- in_ready registered: 1 in EMPTY/HALF, 0 in FULL; updates the cycle after a state change. No combinational path from out_ready to in_ready.
- out_valid = state != EMPTY. When out_valid=0, out_data and out_lane_valid are all-zero (bubble = NOP 0).
- Payload and lane valids move together as one beat; a beat is never split across lanes.
- flush=1 at a clock edge: next state EMPTY, both entries zeroed, in_ready=1; overrides simultaneous accept and drain. The beat presented in the flush cycle is dropped. Downstream may still see out_valid in the flush cycle (pre-edge), and a drain that cycle is legal.
- Reset (rst=0, any time including mid-FULL): immediately EMPTY, all storage zero, out_valid=0, out_lane_valid=0, out_data=0, occupancy=0, in_ready=1. On rst release the first edge behaves as from EMPTY.
- Throughput: 1 beat/cycle sustained when out_ready=1. Latency in->out: 1 cycle.
- Ordering: strict FIFO; skid content always older than any later accept.

Optional Feature:
PIPE_STAGE_PERF_EN defined: adds outputs perf_stall_cnt (32b, increments each cycle out_valid & ~out_ready) and perf_flush_cnt (16b, increments each flush edge while occupancy!=0). Both saturate at all-ones and reset to 0 on rst=0. Not defined: ports and counters absent; no other behaviour change.

Test Plan:
- Reset: rst=0 during FULL with DATA_W=64, LANES=2 -> same cycle out_valid=0, out_data=0, occupancy=0; in_ready=1 after release.
- Streaming: in_valid=1 for 8 beats {lane valids 2'b11, data k}, out_ready=1 -> outputs data 0..7 on consecutive cycles, in_ready never drops.
- Backpressure: out_ready=0 after beat A, send B, C -> A in main, B in skid, occupancy=2, in_ready=0 next cycle, C held upstream; out_ready=1 -> A, B, C delivered in order, no loss or duplication.
- Flush: FULL state, flush=1 with in_valid=1 beat D -> next cycle occupancy=0, out_valid=0, in_ready=1, D never appears.
- Bubble: in_valid=1, in_lane_valid=2'b00 in HALF -> occupancy unchanged, beat absent at output; in_lane_valid=2'b01 -> out_lane_valid=2'b01, lane1 data passed as given.
- Perf (PIPE_STAGE_PERF_EN): 5 cycles out_valid & ~out_ready, then 2 flushes while occupied -> perf_stall_cnt=5, perf_flush_cnt=2; preload 32'hFFFF_FFFF -> stays saturated.
